sokoban_move_engine: RTL and testbench

Game-state engine for the 8×8 Sokoban board. It accepts one direction command at a time, validates the move against the wall, floor and box maps, and updates the man position and box map. It also keeps the step and push counters and detects the win condition. It sits directly upstream of the tile-map render layer and drives that layer's `man`, `box`, `way`, `wall` and `destination` inputs.

---
 rtl/sokoban_pkg.sv | 34 +++
 rtl/sokoban_move_engine_grid_step.sv | 43 ++++
 rtl/sokoban_move_engine.sv | 215 +++++++++++++++++++++
 tb/tb_sokoban_move_engine.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sokoban_pkg.sv
// Shared grid constants, direction codes, FSM states and a passability helper
// for the Sokoban move engine.
package sokoban_pkg;

  localparam int GRID_DIM = 8;

  typedef logic [5:0] cell_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROBE1,
    ST_PROBE2,
    ST_COMMIT,
    ST_EVAL,
    ST_WON
  } state_t;

  typedef enum logic [1:0] {
    MV_REJECT,
    MV_STEP,
    MV_PUSH
  } move_t;

  function automatic logic is_passable(input logic [63:0] way, input logic [63:0] wall,
                                       input logic [63:0] dst, input cell_t c);
    return (way[c] | dst[c]) & ~wall[c];
  endfunction

endpackage

// File: rtl/sokoban_move_engine_grid_step.sv
// Neighbour cell of (cell, dir) on the 8x8 grid with off-grid flag; purely
// combinational, zero latency, no flow control.
module grid_step
  import sokoban_pkg::*;
(
  input  logic [5:0] i_cell,
  input  logic [1:0] i_dir,
  output logic [5:0] o_cell,
  output logic       o_off_grid
);

  localparam logic [2:0] LAST = 3'(GRID_DIM - 1);

  logic [2:0] w_row;
  logic [2:0] w_col;

  assign w_row = i_cell[5:3];
  assign w_col = i_cell[2:0];

  always_comb begin
    o_cell     = i_cell;
    o_off_grid = 1'b0;
    case (i_dir)
      DIR_UP: begin
        o_off_grid = (w_row == 3'd0);
        o_cell     = {w_row - 3'd1, w_col};
      end
      DIR_DOWN: begin
        o_off_grid = (w_row == LAST);
        o_cell     = {w_row + 3'd1, w_col};
      end
      DIR_LEFT: begin
        o_off_grid = (w_col == 3'd0);
        o_cell     = {w_row, w_col - 3'd1};
      end
      default: begin
        o_off_grid = (w_col == LAST);
        o_cell     = {w_row, w_col + 3'd1};
      end
    endcase
  end

endmodule

// File: rtl/sokoban_move_engine.sv
// Sokoban game-state engine: validates one direction command at a time, fixed 4-cycle
// latency, dir_ready only in IDLE (no queuing); optional one-level undo via SOKOBAN_UNDO_EN.
module sokoban_move_engine
  import sokoban_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [5:0]       init_man,
  input  logic [63:0]      init_box,
  input  logic [63:0]      init_way,
  input  logic [63:0]      init_wall,
  input  logic [63:0]      init_dst,
  input  logic             dir_valid,
  input  logic [1:0]       dir,
  output logic             dir_ready,
  input  logic             undo,
  output logic [5:0]       man,
  output logic [63:0]      box,
  output logic [63:0]      way,
  output logic [63:0]      wall,
  output logic [63:0]      destination,
  output logic             move_done,
  output logic             move_ok,
  output logic [CNT_W-1:0] steps,
  output logic [CNT_W-1:0] pushes,
  output logic             win
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_dir;
  cell_t            r_man;
  cell_t            r_t1;
  cell_t            r_t2;
  cell_t            w_t1;
  cell_t            w_t2;
  logic             r_t1_off;
  logic             r_t2_off;
  logic             w_t1_off;
  logic             w_t2_off;
  move_t            r_kind;
  logic [63:0]      r_box;
  logic [63:0]      r_way;
  logic [63:0]      r_wall;
  logic [63:0]      r_dst;
  logic [CNT_W-1:0] r_steps;
  logic [CNT_W-1:0] r_pushes;
  logic             r_win;
  logic             r_move_done;
  logic             r_move_ok;
  logic             w_idle;
  logic             w_accept;
  logic             w_undo_go;
  logic             w_win_now;
  logic             w_t1_blocked;
  logic             w_t2_blocked;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_win_now    = ((r_box & ~r_dst) == 64'd0) && (r_box != 64'd0);
  assign w_t1_blocked = r_t1_off || !is_passable(r_way, r_wall, r_dst, r_t1);
  assign w_t2_blocked = r_t2_off || !is_passable(r_way, r_wall, r_dst, r_t2) || r_box[r_t2];
  assign w_accept     = dir_valid & w_idle & ~w_undo_go;

  grid_step u_step_t1 (.i_cell(r_man), .i_dir(dir),   .o_cell(w_t1), .o_off_grid(w_t1_off));
  grid_step u_step_t2 (.i_cell(r_t1),  .i_dir(r_dir), .o_cell(w_t2), .o_off_grid(w_t2_off));

`ifdef SOKOBAN_UNDO_EN
  logic             r_undo_vld;
  cell_t            r_snap_man;
  logic [63:0]      r_snap_box;
  logic [CNT_W-1:0] r_snap_steps;
  logic [CNT_W-1:0] r_snap_pushes;

  assign w_undo_go = undo & r_undo_vld & w_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_undo_vld    <= 1'b0;
      r_snap_man    <= '0;
      r_snap_box    <= '0;
      r_snap_steps  <= '0;
      r_snap_pushes <= '0;
    end else if (load) begin
      r_undo_vld <= 1'b0;
    end else if (r_state == ST_COMMIT && r_kind != MV_REJECT) begin
      r_undo_vld    <= 1'b1;
      r_snap_man    <= r_man;
      r_snap_box    <= r_box;
      r_snap_steps  <= r_steps;
      r_snap_pushes <= r_pushes;
    end else if (w_undo_go) begin
      r_undo_vld <= 1'b0;
    end
  end
`else
  logic w_unused_undo;
  assign w_unused_undo = undo;
  assign w_undo_go     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_PROBE1;
      ST_PROBE1: w_state_nxt = ST_PROBE2;
      ST_PROBE2: w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_EVAL;
      ST_EVAL:   w_state_nxt = w_win_now ? ST_WON : ST_IDLE;
      ST_WON:    w_state_nxt = ST_WON;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (load) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir       <= '0;
      r_t1        <= '0;
      r_t2        <= '0;
      r_t1_off    <= 1'b0;
      r_t2_off    <= 1'b0;
      r_kind      <= MV_REJECT;
      r_man       <= '0;
      r_box       <= '0;
      r_way       <= '0;
      r_wall      <= '0;
      r_dst       <= '0;
      r_steps     <= '0;
      r_pushes    <= '0;
      r_win       <= 1'b0;
      r_move_done <= 1'b0;
      r_move_ok   <= 1'b0;
    end else if (load) begin
      r_man       <= init_man;
      r_box       <= init_box;
      r_way       <= init_way;
      r_wall      <= init_wall;
      r_dst       <= init_dst;
      r_steps     <= '0;
      r_pushes    <= '0;
      r_win       <= 1'b0;
      r_move_done <= 1'b0;
      r_move_ok   <= 1'b0;
    end else begin
      r_move_done <= 1'b0;
      r_move_ok   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
`ifdef SOKOBAN_UNDO_EN
          if (w_undo_go) begin
            r_man       <= r_snap_man;
            r_box       <= r_snap_box;
            r_steps     <= r_snap_steps;
            r_pushes    <= r_snap_pushes;
            r_move_done <= 1'b1;
            r_move_ok   <= 1'b1;
          end
`endif
          if (w_accept) begin
            r_dir    <= dir;
            r_t1     <= w_t1;
            r_t1_off <= w_t1_off;
          end
        end
        ST_PROBE1: begin
          r_t2     <= w_t2;
          r_t2_off <= w_t2_off;
          if (w_t1_blocked)     r_kind <= MV_REJECT;
          else if (r_box[r_t1]) r_kind <= MV_PUSH;
          else                  r_kind <= MV_STEP;
        end
        ST_PROBE2: begin
          // A box in t1 is only pushable if the cell beyond it is free floor.
          if (r_kind == MV_PUSH && w_t2_blocked) r_kind <= MV_REJECT;
        end
        ST_COMMIT: begin
          r_move_done <= 1'b1;
          r_move_ok   <= (r_kind != MV_REJECT);
          if (r_kind != MV_REJECT) begin
            r_man <= r_t1;
            if (r_steps != {CNT_W{1'b1}}) r_steps <= r_steps + CNT_W'(1);
          end
          if (r_kind == MV_PUSH) begin
            r_box[r_t1] <= 1'b0;
            r_box[r_t2] <= 1'b1;
            if (r_pushes != {CNT_W{1'b1}}) r_pushes <= r_pushes + CNT_W'(1);
          end
        end
        ST_EVAL: r_win <= w_win_now;
        default: ;
      endcase
    end
  end

  assign dir_ready   = w_idle;
  assign man         = r_man;
  assign box         = r_box;
  assign way         = r_way;
  assign wall        = r_wall;
  assign destination = r_dst;
  assign move_done   = r_move_done;
  assign move_ok     = r_move_ok;
  assign steps       = r_steps;
  assign pushes      = r_pushes;
  assign win         = r_win;

endmodule

// File: tb/tb_sokoban_move_engine.sv
// Bench for sokoban_move_engine: directed level scenarios plus randomized commands,
// checked every cycle against a transaction-level game model.
module tb_sokoban_move_engine;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam logic [63:0] ALL1 = {64{1'b1}};
`ifdef SOKOBAN_UNDO_EN
  localparam bit UNDO_EN = 1'b1;
`else
  localparam bit UNDO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load = 1'b0;
  logic [5:0]       init_man = '0;
  logic [63:0]      init_box = '0, init_way = '0, init_wall = '0, init_dst = '0;
  logic             dir_valid = 1'b0;
  logic [1:0]       dir = '0;
  logic             undo = 1'b0;
  logic             dir_ready, move_done, move_ok, win;
  logic [5:0]       man;
  logic [63:0]      box, way, wall, destination;
  logic [CNT_W-1:0] steps, pushes;

  always #5 clk = ~clk;

  sokoban_move_engine #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .init_man(init_man), .init_box(init_box),
    .init_way(init_way), .init_wall(init_wall), .init_dst(init_dst),
    .dir_valid(dir_valid), .dir(dir), .dir_ready(dir_ready), .undo(undo),
    .man(man), .box(box), .way(way), .wall(wall), .destination(destination),
    .move_done(move_done), .move_ok(move_ok), .steps(steps), .pushes(pushes), .win(win)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Game model: board state plus a count of edges since the command was accepted.
  logic [63:0] m_box, m_way, m_wall, m_dst, u_box;
  int m_man, m_steps, m_pushes, m_dir, m_phase;
  int u_man, u_steps, u_pushes;
  bit m_win, m_won, m_done, m_ok, u_vld;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_box = '0; m_way = '0; m_wall = '0; m_dst = '0;
    m_man = 0; m_steps = 0; m_pushes = 0; m_dir = 0; m_phase = 0;
    m_win = 0; m_won = 0; m_done = 0; m_ok = 0; u_vld = 0;
    u_box = '0; u_man = 0; u_steps = 0; u_pushes = 0;
  endfunction

  function automatic int nb(input int c, input int d);
    int r, k;
    r = c / 8;
    k = c % 8;
    case (d)
      0:       r = r - 1;
      1:       r = r + 1;
      2:       k = k - 1;
      default: k = k + 1;
    endcase
    if (r < 0 || r > 7 || k < 0 || k > 7) return -1;
    return r * 8 + k;
  endfunction

  function automatic bit pass(input int c);
    if (c < 0) return 1'b0;
    return (m_way[c] | m_dst[c]) && !m_wall[c];
  endfunction

  function automatic void apply_move();
    int t1, t2;
    bit ok, push;
    t1 = nb(m_man, m_dir);
    t2 = -1;
    ok = pass(t1);
    push = 1'b0;
    if (ok && m_box[t1]) begin
      t2 = nb(t1, m_dir);
      push = 1'b1;
      if (!pass(t2) || m_box[t2]) ok = 1'b0;
    end
    m_done = 1'b1;
    m_ok = ok;
    if (ok) begin
      u_man = m_man; u_box = m_box; u_steps = m_steps; u_pushes = m_pushes; u_vld = 1'b1;
      if (push) begin
        m_box[t1] = 1'b0;
        m_box[t2] = 1'b1;
        if (m_pushes < CMAX) m_pushes++;
      end
      m_man = t1;
      if (m_steps < CMAX) m_steps++;
    end
  endfunction

  // Advances the model across the next rising edge for the given inputs.
  function automatic void model_edge(input bit l, input bit dv, input int d, input bit u);
    m_done = 1'b0;
    m_ok = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (l) begin
      m_man = int'(init_man); m_box = init_box; m_way = init_way; m_wall = init_wall;
      m_dst = init_dst; m_steps = 0; m_pushes = 0; m_win = 0; m_won = 0;
      m_phase = 0; u_vld = 0;
    end else if (m_phase == 0) begin
      if (!m_won) begin
        if (UNDO_EN && u && u_vld) begin
          m_man = u_man; m_box = u_box; m_steps = u_steps; m_pushes = u_pushes;
          m_done = 1'b1; m_ok = 1'b1; u_vld = 1'b0;
        end else if (dv) begin
          m_dir = d;
          m_phase = 1;
        end
      end
    end else if (m_phase == 3) begin
      apply_move();
      m_phase = 4;
    end else if (m_phase == 4) begin
      m_win = (m_box != 64'd0) && ((m_box & ~m_dst) == 64'd0);
      m_won = m_win;
      m_phase = 0;
    end else begin
      m_phase++;
    end
  endfunction

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("man", 64'(man), 64'(m_man));
      chk("box", box, m_box);
      chk("way", way, m_way);
      chk("wall", wall, m_wall);
      chk("destination", destination, m_dst);
      chk("steps", 64'(steps), 64'(m_steps));
      chk("pushes", 64'(pushes), 64'(m_pushes));
      chk("win", 64'(win), 64'(m_win));
      chk("move_done", 64'(move_done), 64'(m_done));
      chk("move_ok", 64'(move_ok), 64'(m_ok));
      chk("dir_ready", 64'(dir_ready), 64'(m_phase == 0 && !m_won));
    end
  end

  task automatic tick(input bit l, input bit dv, input logic [1:0] d, input bit u);
    load = l; dir_valid = dv; dir = d; undo = u;
    model_edge(l, dv, int'(d), u);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [5:0] mn, input logic [63:0] bx, input logic [63:0] wy,
                         input logic [63:0] wl, input logic [63:0] ds);
    init_man = mn; init_box = bx; init_way = wy; init_wall = wl; init_dst = ds;
    tick(1'b1, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic move(input logic [1:0] d, output bit dn, output bit ok);
    tick(1'b0, 1'b1, d, 1'b0);
    tick(1'b0, 1'b0, 2'd0, 1'b0);
    tick(1'b0, 1'b0, 2'd0, 1'b0);
    chk("done_not_early", 64'(move_done), 64'd0);
    tick(1'b0, 1'b0, 2'd0, 1'b0);
    dn = move_done;
    ok = move_ok;
    tick(1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    bit dn, ok;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_ready", 64'(dir_ready), 64'd1);
    chk("reset_man", 64'(man), 64'd0);
    chk("reset_done", 64'(move_done), 64'd0);
    chk("reset_steps", 64'(steps), 64'd0);

    // Plain step on open floor.
    do_load(6'd27, 64'd0, ALL1, 64'd0, 64'd0);
    move(2'd3, dn, ok);
    chk("step_done", 64'(dn), 64'd1);
    chk("step_ok", 64'(ok), 64'd1);
    chk("step_man", 64'(man), 64'd28);
    chk("step_steps", 64'(steps), 64'd1);
    chk("step_pushes", 64'(pushes), 64'd0);
    chk("step_ready", 64'(dir_ready), 64'd1);

    // Push onto the only destination wins; further commands are dropped.
    do_load(6'd27, 64'd1 << 28, ALL1, 64'd0, 64'd1 << 29);
    tick(1'b0, 1'b1, 2'd3, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 2'd0, 1'b0);
    chk("push_done", 64'(move_done), 64'd1);
    chk("push_box", box, 64'd1 << 29);
    chk("push_man", 64'(man), 64'd28);
    chk("push_pushes", 64'(pushes), 64'd1);
    chk("push_win_not_yet", 64'(win), 64'd0);
    tick(1'b0, 1'b0, 2'd0, 1'b0);
    chk("push_win", 64'(win), 64'd1);
    chk("won_ready", 64'(dir_ready), 64'd0);
    tick(1'b0, 1'b1, 2'd2, 1'b0);
    repeat (5) tick(1'b0, 1'b0, 2'd0, 1'b0);
    chk("won_man_held", 64'(man), 64'd28);

    // Walls and box chains reject.
    do_load(6'd27, 64'd0, ALL1, 64'd1 << 28, 64'd0);
    move(2'd3, dn, ok);
    chk("wall_done", 64'(dn), 64'd1);
    chk("wall_ok", 64'(ok), 64'd0);
    chk("wall_man", 64'(man), 64'd27);
    chk("wall_steps", 64'(steps), 64'd0);
    do_load(6'd27, (64'd1 << 28) | (64'd1 << 29), ALL1, 64'd0, 64'd0);
    move(2'd3, dn, ok);
    chk("boxes_ok", 64'(ok), 64'd0);
    chk("boxes_box", box, (64'd1 << 28) | (64'd1 << 29));

    // Edges never wrap.
    do_load(6'd7, 64'd0, ALL1, 64'd0, 64'd0);
    move(2'd3, dn, ok);
    chk("edge_right_ok", 64'(ok), 64'd0);
    chk("edge_right_man", 64'(man), 64'd7);
    do_load(6'd0, 64'd0, ALL1, 64'd0, 64'd0);
    move(2'd0, dn, ok);
    chk("edge_up_ok", 64'(ok), 64'd0);
    do_load(6'd8, 64'd0, ALL1, 64'd0, 64'd0);
    move(2'd2, dn, ok);
    chk("edge_left_ok", 64'(ok), 64'd0);
    chk("edge_left_man", 64'(man), 64'd8);

    // Load during PROBE1 aborts the command.
    do_load(6'd27, 64'd0, ALL1, 64'd0, 64'd0);
    tick(1'b0, 1'b1, 2'd3, 1'b0);
    do_load(6'd10, 64'd1 << 40, ALL1, 64'd1 << 5, 64'd1 << 41);
    chk("abort_man", 64'(man), 64'd10);
    chk("abort_box", box, 64'd1 << 40);
    chk("abort_wall", wall, 64'd1 << 5);
    chk("abort_ready", 64'(dir_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 2'd0, 1'b0);
      chk("abort_no_done", 64'(move_done), 64'd0);
    end
    init_man = 6'd20;
    tick(1'b1, 1'b1, 2'd3, 1'b0);
    chk("load_wins_ready", 64'(dir_ready), 64'd1);
    chk("load_wins_man", 64'(man), 64'd20);
    repeat (5) tick(1'b0, 1'b0, 2'd0, 1'b0);
    chk("load_wins_man_held", 64'(man), 64'd20);

    // Undo after a push.
    do_load(6'd27, 64'd1 << 28, ALL1, 64'd0, 64'd0);
    move(2'd3, dn, ok);
    chk("undo_pre_box", box, 64'd1 << 29);
    tick(1'b0, 1'b0, 2'd0, 1'b1);
    if (UNDO_EN) begin
      chk("undo_done", 64'(move_done), 64'd1);
      chk("undo_man", 64'(man), 64'd27);
      chk("undo_box", box, 64'd1 << 28);
      chk("undo_steps", 64'(steps), 64'd0);
    end else begin
      chk("undo_ignored_done", 64'(move_done), 64'd0);
      chk("undo_ignored_man", 64'(man), 64'd28);
    end
    tick(1'b0, 1'b0, 2'd0, 1'b1);
    chk("undo_second_done", 64'(move_done), 64'd0);
    tick(1'b0, 1'b0, 2'd0, 1'b0);

    // Step counter saturates.
    do_load(6'd0, 64'd0, ALL1, 64'd0, 64'd0);
    for (int i = 0; i < 20; i++) move((i % 2 == 0) ? 2'd3 : 2'd2, dn, ok);
    chk("sat_steps", 64'(steps), 64'(CMAX));
    chk("sat_man", 64'(man), 64'd0);

    // Asynchronous reset in the middle of a command.
    do_load(6'd27, 64'd0, ALL1, 64'd0, 64'd0);
    tick(1'b0, 1'b1, 2'd3, 1'b0);
    tick(1'b0, 1'b0, 2'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_man", 64'(man), 64'd0);
    chk("arst_way", way, 64'd0);
    chk("arst_ready", 64'(dir_ready), 64'd1);
    @(negedge clk);
    tick(1'b0, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;

    // Randomized levels and commands.
    for (int i = 0; i < 4000; i++) begin
      bit l, dv, u;
      l = ($urandom_range(0, 99) < 3) || (i == 0);
      if (l) begin
        init_way  = ($urandom_range(0, 2) == 0) ? ALL1 : ({$urandom, $urandom} | {$urandom, $urandom});
        init_wall = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        init_box  = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        init_dst  = {$urandom, $urandom} & {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) init_dst = init_box | (init_box << 1);
        init_man  = 6'($urandom_range(0, 63));
      end
      dv = ($urandom_range(0, 99) < 60);
      u  = ($urandom_range(0, 99) < 8);
      tick(l, dv, 2'($urandom_range(0, 3)), u);
    end
    tick(1'b0, 1'b0, 2'd0, 1'b0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
